// File: rtl/float_copro_queue.sv
// Queued float coprocessor control: a command FIFO feeding one op at a time to an external datapath.
// Optional FLOAT_COPRO_ERR_EN adds copro_error, flagging illegal opcodes with a zero result.
module float_copro_queue #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 11,
  parameter int DEPTH  = 4,
  parameter int T_ADD  = 3,
  parameter int T_SUB  = 2,
  parameter int T_MULT = 5,
  parameter int T_DIV  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       copro_valid,
  output logic                       copro_ready,
  input  logic [OP_W-1:0]            copro_opcode,
  input  logic [DATA_W-1:0]          copro_op0,
  input  logic [DATA_W-1:0]          copro_op1,
  output logic                       copro_complete,
  input  logic                       copro_accept,
  output logic [DATA_W-1:0]          copro_result,
  output logic [$clog2(DEPTH):0]     copro_level,
  output logic [OP_W-1:0]            dp_opcode,
  output logic [DATA_W-1:0]          dp_op0,
  output logic [DATA_W-1:0]          dp_op1,
  input  logic [DATA_W-1:0]          dp_result
`ifdef FLOAT_COPRO_ERR_EN
  ,
  output logic                       copro_error
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(T_ADD + T_SUB + T_MULT + T_DIV + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  cmd_t              exec_q, exec_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              complete_q, complete_d;
  logic              push, pop, legal;
  cmd_t              head;
`ifdef FLOAT_COPRO_ERR_EN
  logic              err_q, err_d;
`endif

  // Down-counter start value; illegal opcodes take a single cycle.
  function automatic logic [CW-1:0] lat_m1(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(0): lat_m1 = CW'(T_ADD - 1);
      OP_W'(1): lat_m1 = CW'(T_SUB - 1);
      OP_W'(2): lat_m1 = CW'(T_MULT - 1);
      OP_W'(3): lat_m1 = CW'(T_DIV - 1);
      default:  lat_m1 = '0;
    endcase
  endfunction

  assign copro_ready = (count_q < LW'(DEPTH));
  assign push        = copro_valid && copro_ready;
  assign head        = mem_q[rd_ptr_q];
  assign legal       = (exec_q.op < OP_W'(4));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exec_d     = exec_q;
    result_d   = result_q;
    complete_d = complete_q;
    pop        = 1'b0;
`ifdef FLOAT_COPRO_ERR_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          exec_d  = head;
          cnt_d   = lat_m1(head.op);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          complete_d = 1'b1;
          result_d   = dp_result;
          state_d    = DONE;
`ifdef FLOAT_COPRO_ERR_EN
          err_d = !legal;
          if (!legal) result_d = '0;
`endif
        end
      end
      DONE: begin
        if (copro_accept) begin
          complete_d = 1'b0;
`ifdef FLOAT_COPRO_ERR_EN
          err_d = 1'b0;
`endif
          // Back-to-back: the next op starts on the same edge as the accept.
          if (count_q != '0) begin
            pop     = 1'b1;
            exec_d  = head;
            cnt_d   = lat_m1(head.op);
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {copro_opcode, copro_op0, copro_op1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      exec_q     <= '0;
      result_q   <= '0;
      complete_q <= 1'b0;
`ifdef FLOAT_COPRO_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exec_q     <= exec_d;
      result_q   <= result_d;
      complete_q <= complete_d;
`ifdef FLOAT_COPRO_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign copro_complete = complete_q;
  assign copro_result   = result_q;
  assign copro_level    = count_q;
  assign dp_opcode      = exec_q.op;
  assign dp_op0         = exec_q.a;
  assign dp_op1         = exec_q.b;
`ifdef FLOAT_COPRO_ERR_EN
  assign copro_error    = err_q;
`endif

endmodule

// File: tb/tb_float_copro_queue.sv
// Scoreboard bench for float_copro_queue: directed pushes queue expected results,
// a negedge monitor compares each newly presented result in order.
module tb_float_copro_queue;
  localparam int DATA_W = 32;
  localparam int OP_W   = 11;
  localparam int DEPTH  = 4;
  localparam int T_ADD  = 3;
  localparam int T_SUB  = 2;
  localparam int T_MULT = 5;
  localparam int T_DIV  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              copro_valid = 1'b0;
  logic              copro_accept = 1'b0;
  logic [OP_W-1:0]   copro_opcode = '0;
  logic [DATA_W-1:0] copro_op0 = '0;
  logic [DATA_W-1:0] copro_op1 = '0;
  logic              copro_ready, copro_complete;
  logic [DATA_W-1:0] copro_result, dp_op0, dp_op1, dp_result;
  logic [OP_W-1:0]   dp_opcode;
  logic [$clog2(DEPTH):0] copro_level;
`ifdef FLOAT_COPRO_ERR_EN
  logic              copro_error;
`endif

  float_copro_queue #(
    .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH),
    .T_ADD(T_ADD), .T_SUB(T_SUB), .T_MULT(T_MULT), .T_DIV(T_DIV)
  ) dut (
    .clk(clk), .reset(reset),
    .copro_valid(copro_valid), .copro_ready(copro_ready),
    .copro_opcode(copro_opcode), .copro_op0(copro_op0), .copro_op1(copro_op1),
    .copro_complete(copro_complete), .copro_accept(copro_accept),
    .copro_result(copro_result), .copro_level(copro_level),
    .dp_opcode(dp_opcode), .dp_op0(dp_op0), .dp_op1(dp_op1), .dp_result(dp_result)
`ifdef FLOAT_COPRO_ERR_EN
    , .copro_error(copro_error)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in datapath: a few float adds by lookup, integer ops otherwise.
  function automatic logic [31:0] dp_model(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      11'd0: begin
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        return a + b;
      end
      11'd1: return a - b;
      11'd2: return a * b;
      11'd3: return (b == 0) ? 32'h0 : a / b;
      default: return a ^ b;
    endcase
  endfunction

  assign dp_result = dp_model(dp_opcode, dp_op0, dp_op1);

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   max_level = 0;
  logic prev_c = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1000;
  endfunction

  // Monitor: every rising copro_complete is a new result, checked against the queue head.
  always @(negedge clk) begin
    if (reset) begin
      prev_c = 1'b0;
    end else begin
      if (int'(copro_level) > max_level) max_level = int'(copro_level);
      if (copro_complete && !prev_c) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_complete actual=0x%0h required=none", copro_result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", copro_result, e.res);
`ifdef FLOAT_COPRO_ERR_EN
          check("sb_error", 32'(copro_error), 32'(e.err));
`endif
        end
      end
      prev_c = copro_complete;
    end
  end

  task automatic push(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic err, output bit acc, output int pc);
    @(negedge clk);
    copro_valid  = 1'b1;
    copro_opcode = op;
    copro_op0    = a;
    copro_op1    = b;
    acc = copro_ready;
    pc  = cyc + 1;
    if (acc) exp_q.push_back('{res, err});
    @(posedge clk);
    #1 copro_valid = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget, input string name);
    for (int i = 0; i < budget && rise_q.size() < n; i++) @(negedge clk);
    check(name, rise_q.size(), n);
  endtask

  initial begin
    bit acc, acc5, acc6;
    int p0, pc;
    logic [31:0] ill_res;
    logic        ill_err;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_complete", 32'(copro_complete), 0);
    check("rst_result", copro_result, 0);
    check("rst_level", 32'(copro_level), 0);
    check("rst_ready", 32'(copro_ready), 1);
    check("rst_dp_opcode", 32'(dp_opcode), 0);
    check("rst_dp_op0", dp_op0, 0);
`ifdef FLOAT_COPRO_ERR_EN
    check("rst_error", 32'(copro_error), 0);
`endif
    reset = 1'b0;

    // Single add: 1.0 + 2.0
    rise_q.delete();
    push(11'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, acc, pc);
    wait_rises(1, 20, "t1_rise");
    check("t1_latency", rise_at(0) - pc, 4);
    repeat (3) @(negedge clk);
    check("t1_hold_complete", 32'(copro_complete), 1);
    check("t1_hold_result", copro_result, 32'h40400000);
    copro_accept = 1'b1;
    @(negedge clk);
    check("t1_drop_complete", 32'(copro_complete), 0);
    copro_accept = 1'b0;

    // Back-to-back burst with accept held; rise spacing is LAT+1 (one DONE cycle each)
    rise_q.delete();
    max_level = 0;
    copro_accept = 1'b1;
    push(11'd1, 32'd10, 32'd3, 32'd7, 1'b0, acc, p0);
    push(11'd2, 32'd6, 32'd7, 32'd42, 1'b0, acc, pc);
    push(11'd3, 32'd100, 32'd7, 32'd14, 1'b0, acc, pc);
    push(11'd0, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, acc, pc);
    wait_rises(4, 80, "t2_rises");
    check("t2_first", rise_at(0) - p0, 1 + T_SUB);
    check("t2_gap_mul", rise_at(1) - rise_at(0), T_MULT + 1);
    check("t2_gap_div", rise_at(2) - rise_at(1), T_DIV + 1);
    check("t2_gap_add", rise_at(3) - rise_at(2), T_ADD + 1);
    check("t2_max_level", max_level, 3);
    repeat (2) @(negedge clk);
    copro_accept = 1'b0;
    check("t2_level_end", 32'(copro_level), 0);

    // Fill while the first result is held
    rise_q.delete();
    push(11'd1, 32'd20, 32'd5, 32'd15, 1'b0, acc, pc);
    push(11'd2, 32'd3, 32'd3, 32'd9, 1'b0, acc, pc);
    push(11'd3, 32'd9, 32'd3, 32'd3, 1'b0, acc, pc);
    push(11'd1, 32'd1, 32'd1, 32'd0, 1'b0, acc, pc);
    push(11'd2, 32'd2, 32'd2, 32'd4, 1'b0, acc5, pc);
    push(11'd0, 32'd1, 32'd2, 32'd3, 1'b0, acc6, pc);
    check("t3_fifth_accepted", 32'(acc5), 1);
    check("t3_sixth_refused", 32'(acc6), 0);
    @(negedge clk);
    check("t3_level_full", 32'(copro_level), 4);
    check("t3_ready_low", 32'(copro_ready), 0);
    repeat (10) @(negedge clk);
    check("t3_held_complete", 32'(copro_complete), 1);
    check("t3_held_result", copro_result, 32'd15);
    check("t3_one_rise", rise_q.size(), 1);

    // Push while full, same-edge pop via accept: push dropped, only the pop counts
    @(negedge clk);
    copro_valid  = 1'b1;
    copro_opcode = 11'd0;
    copro_op0    = 32'd5;
    copro_op1    = 32'd5;
    copro_accept = 1'b1;
    check("t4_ready_pre", 32'(copro_ready), 0);
    @(posedge clk);
    #1;
    copro_valid  = 1'b0;
    copro_accept = 1'b0;
    @(negedge clk);
    check("t4_level_after", 32'(copro_level), 3);
    copro_accept = 1'b1;
    wait_rises(5, 100, "t4_drain_rises");
    repeat (5) @(negedge clk);
    check("t4_no_extra", rise_q.size(), 5);
    check("t4_level_empty", 32'(copro_level), 0);

    // Reset during EXEC of a mul with two ops queued
    rise_q.delete();
    push(11'd2, 32'd11, 32'd2, 32'd22, 1'b0, acc, pc);
    push(11'd1, 32'd9, 32'd4, 32'd5, 1'b0, acc, pc);
    push(11'd0, 32'd1, 32'd1, 32'd2, 1'b0, acc, pc);
    @(negedge clk);
    check("t5_level_pre", 32'(copro_level), 2);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("t5_rst_complete", 32'(copro_complete), 0);
    check("t5_rst_level", 32'(copro_level), 0);
    check("t5_rst_dp_opcode", 32'(dp_opcode), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_no_rises", rise_q.size(), 0);
    check("t5_complete_low", 32'(copro_complete), 0);
    copro_accept = 1'b0;

    // Illegal opcode 7
`ifdef FLOAT_COPRO_ERR_EN
    ill_res = 32'h0;
    ill_err = 1'b1;
`else
    ill_res = 32'hFF;
    ill_err = 1'b0;
`endif
    rise_q.delete();
    push(11'd7, 32'hF0, 32'h0F, ill_res, ill_err, acc, pc);
    wait_rises(1, 20, "t6_rise");
    check("t6_latency", rise_at(0) - pc, 2);
    check("t6_result", copro_result, ill_res);
    copro_accept = 1'b1;
    @(negedge clk);
    check("t6_complete_clear", 32'(copro_complete), 0);
`ifdef FLOAT_COPRO_ERR_EN
    check("t6_error_clear", 32'(copro_error), 0);
`endif
    copro_accept = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
